icount_arbiter: RTL and testbench

Shared instruction-count table with arbitration between two instruction-code sources and one query/readout port. Each accepted code increments its `2^ICODESIZE`-entry counter through an internal read-modify-write pipeline with write-to-read forwarding. The query port reads, and optionally clears, any counter. The block sits behind the decode stage, replacing per-source counter instances with one arbitrated table.

---
 rtl/icount_arbiter.sv | 176 +++++++++++++++++
 tb/tb_icount_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/icount_arbiter.sv
// icount_arbiter
//
// Shared instruction-count table. Two code sources (req0/req1) and one
// query port compete for a single grant per cycle. Each accepted code
// increments its entry through a three-stage read-modify-write pipeline:
//   A (grant)  : selected code/op/clear registered
//   B          : table read, with forwarding from the stage-C write
//   C          : write-back (read+1 for INC, 0 for QUERY+clear)
// After reset the FSM spends 2^ICODESIZE cycles zeroing the table (busy=1)
// before any grant is issued.
//
// Configuration macro: ICOUNT_SATURATE_EN
//   defined   : counters stick at all-ones, sat_flag pulses on a blocked INC
//   undefined : counters wrap, sat_flag tied low
//
// Ports
//   clock, reset                 rising-edge clock, async active-low reset
//   req{0,1}_valid/_icode/_ready code sources (ready = granted this cycle)
//   qry_valid/_icode/_clear/_ready  query port, highest priority
//   rsp_valid, rsp_data          query response two cycles after grant
//   busy                         table initialisation in progress
//   sat_flag                     saturation pulse (stage C of the INC)
module icount_arbiter #(
  parameter int ICODESIZE = 4,
  parameter int COUNTBITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [ICODESIZE-1:0] req0_icode,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ICODESIZE-1:0] req1_icode,
  output logic                 req1_ready,
  input  logic                 qry_valid,
  input  logic [ICODESIZE-1:0] qry_icode,
  input  logic                 qry_clear,
  output logic                 qry_ready,
  output logic                 rsp_valid,
  output logic [COUNTBITS-1:0] rsp_data,
  output logic                 busy,
  output logic                 sat_flag
);

  localparam int ENTRIES = 1 << ICODESIZE;
  localparam int STAGES  = 2;

  typedef logic [ICODESIZE-1:0] code_t;
  typedef logic [COUNTBITS-1:0] cnt_t;
  typedef enum logic { S_CLEAR, S_RUN } state_e;
  typedef enum logic { OP_INC, OP_QUERY } op_e;
  typedef struct packed {
    op_e   op;
    logic  clr;
    code_t code;
  } req_t;

  state_e state_q, state_d;
  code_t  ptr_q, ptr_d;
  logic   rr_last_q, rr_last_d;   // 1: source 1 was granted last
  logic   g0, g1, gq, clr_we;

  // [0] = grant this cycle, [1] = op in stage B, [2] = op in stage C
  logic [STAGES:0] vld_pipe;
  logic [STAGES:1] vld_pipe_q;
  req_t            a_d, b_q, c_q;
  cnt_t            b_rd, c_rd_q, c_wdata;
  logic            c_we, c_sat;

  cnt_t            tbl_q [ENTRIES];
  logic            tbl_we;
  code_t           tbl_waddr;
  cnt_t            tbl_wdata;

  logic            rsp_valid_q;
  cnt_t            rsp_data_q;

  // ---------------------------------------------------------------- FSM / arbiter
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rr_last_d = rr_last_q;
    clr_we    = 1'b0;
    g0        = 1'b0;
    g1        = 1'b0;
    gq        = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == code_t'(ENTRIES - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (qry_valid) begin
          gq = 1'b1;
        end else if (req0_valid && (!req1_valid || rr_last_q)) begin
          g0        = 1'b1;
          rr_last_d = 1'b0;
        end else if (req1_valid) begin
          g1        = 1'b1;
          rr_last_d = 1'b1;
        end
      end
    endcase
  end

  assign req0_ready = g0;
  assign req1_ready = g1;
  assign qry_ready  = gq;
  assign busy       = (state_q == S_CLEAR);

  // ---------------------------------------------------------------- stage A payload
  always_comb begin
    a_d = '{op: OP_INC, clr: 1'b0, code: req0_icode};
    if (gq)      a_d = '{op: OP_QUERY, clr: qry_clear, code: qry_icode};
    else if (g1) a_d.code = req1_icode;
  end

  assign vld_pipe = {vld_pipe_q, g0 | g1 | gq};

  // ---------------------------------------------------------------- stage C write-back
`ifdef ICOUNT_SATURATE_EN
  assign c_sat = vld_pipe[2] && (c_q.op == OP_INC) && (&c_rd_q);
`else
  assign c_sat = 1'b0;
`endif
  assign sat_flag = c_sat;

  always_comb begin
    c_we    = vld_pipe[2] && ((c_q.op == OP_INC) || c_q.clr);
    c_wdata = '0;
    if (c_q.op == OP_INC) c_wdata = c_sat ? c_rd_q : c_rd_q + 1'b1;
  end

  // Stage B reads the entry stage C is writing this cycle only on
  // back-to-back grants to the same code; take the in-flight value.
  assign b_rd = (c_we && (c_q.code == b_q.code)) ? c_wdata : tbl_q[b_q.code];

  // CLEAR and stage C never overlap: the pipeline is empty while clearing.
  assign tbl_we    = clr_we | c_we;
  assign tbl_waddr = clr_we ? ptr_q : c_q.code;
  assign tbl_wdata = clr_we ? '0 : c_wdata;

  always_ff @(posedge clock) begin
    if (tbl_we) tbl_q[tbl_waddr] <= tbl_wdata;
  end

  // ---------------------------------------------------------------- state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_CLEAR;
      ptr_q       <= '0;
      rr_last_q   <= 1'b1;
      vld_pipe_q  <= '0;
      b_q         <= '0;
      c_q         <= '0;
      c_rd_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rr_last_q   <= rr_last_d;
      vld_pipe_q  <= vld_pipe[STAGES-1:0];
      b_q         <= a_d;
      c_q         <= b_q;
      c_rd_q      <= b_rd;
      rsp_valid_q <= vld_pipe[1] && (b_q.op == OP_QUERY);
      if (vld_pipe[1] && (b_q.op == OP_QUERY)) rsp_data_q <= b_rd;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_icount_arbiter.sv
// Randomised + directed bench for icount_arbiter against a transaction-level
// model: counts live in a plain array updated at grant time; query results
// and saturation pulses are delayed two cycles through a small pipe.
module tb_icount_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid, qry_valid, qry_clear;
  logic [3:0] req0_icode, req1_icode, qry_icode;
  logic       req0_ready, req1_ready, qry_ready;
  logic       rsp_valid, busy, sat_flag;
  logic [3:0] rsp_data;

  icount_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_icode(req0_icode), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_icode(req1_icode), .req1_ready(req1_ready),
    .qry_valid(qry_valid), .qry_icode(qry_icode), .qry_clear(qry_clear),
    .qry_ready(qry_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .sat_flag(sat_flag)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_cnt [16];
  bit m_run;
  int m_cc;
  int m_last_src;           // source granted last (0/1)
  int m_last;               // last response value
  bit p1_v, p2_v, p1_s, p2_s;
  int p1_d, p2_d;
  bit g0, g1, gq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_run = 0; m_cc = 0; m_last_src = 1; m_last = 0;
    p1_v = 0; p2_v = 0; p1_s = 0; p2_s = 0; p1_d = 0; p2_d = 0;
  endtask

  // Called at a negedge; drives one cycle, checks, advances to next negedge.
  task automatic step(input bit v0, input bit [3:0] c0, input bit v1, input bit [3:0] c1,
                      input bit qv, input bit [3:0] qc, input bit qcl);
    bit       nv, ns;
    int       nd;
    bit [3:0] code;
    req0_valid = v0; req0_icode = c0;
    req1_valid = v1; req1_icode = c1;
    qry_valid  = qv; qry_icode  = qc; qry_clear = qcl;
    #1;
    g0 = 0; g1 = 0; gq = 0;
    if (m_run) begin
      if (qv)            gq = 1;
      else if (v0 && v1) begin if (m_last_src == 1) g0 = 1; else g1 = 1; end
      else begin g0 = v0; g1 = v1; end
    end
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("qry_ready",  qry_ready,  gq);
    chk("busy",       busy,       !m_run);
    chk("rsp_valid",  rsp_valid,  p2_v);
    chk("rsp_data",   rsp_data,   p2_v ? p2_d : m_last);
    chk("sat_flag",   sat_flag,   p2_s);
    if (p2_v) m_last = p2_d;
    nv = 0; nd = 0; ns = 0;
    if (gq) begin
      nv = 1; nd = m_cnt[qc];
      if (qcl) m_cnt[qc] = 0;
    end
    if (g0 || g1) begin
      code = g0 ? c0 : c1;
      m_last_src = g0 ? 0 : 1;
`ifdef ICOUNT_SATURATE_EN
      if (m_cnt[code] == 15) ns = 1;
      else m_cnt[code] = m_cnt[code] + 1;
`else
      m_cnt[code] = (m_cnt[code] + 1) % 16;
`endif
    end
    p2_v = p1_v; p2_d = p1_d; p2_s = p1_s;
    p1_v = nv;   p1_d = nd;   p1_s = ns;
    if (!m_run) begin
      m_cc++;
      if (m_cc == 16) m_run = 1;
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic query(input bit [3:0] c, input bit clr);
    step(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, c, clr);
  endtask

  // Called at a negedge; returns at a negedge with reset released.
  task automatic do_reset(input int ncyc);
    reset = 1'b0;
    req0_valid = 0; req1_valid = 0; qry_valid = 0; qry_clear = 0;
    req0_icode = 0; req1_icode = 0; qry_icode = 0;
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_qry_ready",  qry_ready,  0);
    chk("rst_rsp_valid",  rsp_valid,  0);
    chk("rst_rsp_data",   rsp_data,   0);
    chk("rst_busy",       busy,       1);
    chk("rst_sat_flag",   sat_flag,   0);
    model_reset();
    repeat (ncyc) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    bit       r0v, r1v, rqv, rqc;
    bit [3:0] r0c, r1c, rqi;
    reset = 1'b0;
    req0_valid = 0; req1_valid = 0; qry_valid = 0; qry_clear = 0;
    req0_icode = 0; req1_icode = 0; qry_icode = 0;
    model_reset();
    @(negedge clock);
    do_reset(2);

    // init: req0 held through CLEAR, granted on the 17th cycle
    for (int i = 0; i < 17; i++) step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    idle(1);
    for (int c = 0; c < 16; c++) query(c[3:0], 1'b0);
    idle(3);

    // same-address stream, then query on the next cycle
    repeat (5) step(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    query(4'd3, 1'b0);
    idle(3);

    // round-robin from a fresh reset (source 1 last -> req0 first)
    do_reset(2);
    idle(16);
    repeat (6) step(1'b1, 4'd1, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
    query(4'd1, 1'b0);
    query(4'd2, 1'b0);
    idle(3);

    // query priority with clear
    repeat (4) step(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd7, 1'b0, 4'd0, 1'b1, 4'd7, 1'b1);
    step(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    idle(2);
    query(4'd7, 1'b0);
    idle(3);

    // overflow / saturation
    repeat (17) step(1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    query(4'd9, 1'b0);
    idle(3);

    // reset one cycle after a query grant
    step(1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 4'd9, 1'b0);
    do_reset(3);
    idle(16);
    for (int c = 0; c < 16; c++) query(c[3:0], 1'b0);
    idle(3);

    // randomised traffic; ungranted sources hold valid/code
    r0v = 0; r1v = 0; rqv = 0; rqc = 0; r0c = 0; r1c = 0; rqi = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(r0v && !g0) || i == 0) begin
        r0v = ($urandom_range(0, 2) != 0);
        r0c = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      end
      if (!(r1v && !g1) || i == 0) begin
        r1v = ($urandom_range(0, 2) != 0);
        r1c = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      end
      rqv = ($urandom_range(0, 4) == 0);
      rqi = 4'($urandom_range(0, 3));
      rqc = ($urandom_range(0, 3) == 0);
      step(r0v, r0c, r1v, r1c, rqv, rqi, rqc);
    end
    idle(3);
    for (int c = 0; c < 16; c++) query(c[3:0], 1'b0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
